dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the MEM-stage side of the EX/MEM boundary.
- Accepts the MemRead/MemWrite, address and store-data outputs of the EX/MEM pipeline register, services them from an internal word array with programmable wait states, and returns load data.
- Raises a stall so the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM until the access completes.

Parameters:
- DEPTH, 256, number of 32-bit words in the array (power of two).
- LATENCY, 2, wait cycles per access (legal range 1..15).

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- MemRead_i  input  1  load request from EX/MEM.
- MemWrite_i  input  1  store request from EX/MEM.
- addr_i  input  32  byte address (EX/MEM ALU result).
- data_i  input  32  store data (EX/MEM forwarded rt data).
- data_o  output  32  load data, valid while ack_o=1; held until the next load completes.
- stall_o  output  1  pipeline freeze request.
- ack_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, cnt=0, data_o=0, ack_o=0.
  - stall_o=0 while in reset.
  - Array contents are not reset; they persist across reset.
- Word index = addr_i[log2(DEPTH)+1:2]. addr_i[1:0] and the bits above the index are ignored, so addresses wrap modulo DEPTH*4.
- Request = MemRead_i | MemWrite_i. If both are high, the access is a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ack_o=0.
  - stall_o = request (combinational, same cycle the request appears).
  - On request: latch op, index and data_i; cnt<=LATENCY-1; go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - stall_o=1, ack_o=0.
  - cnt>0: cnt<=cnt-1.
  - cnt==0: perform the access on this edge. A write sets mem[idx]<=latched data. A read sets data_o<=mem[idx]. Go to DONE.
  - Inputs are ignored in BUSY; the latched copy is used.
- DONE:
  - stall_o=0, ack_o=1 (registered, exactly one cycle).
  - The pipeline advances at the end of this cycle.
  - Go to IDLE unconditionally. Requests visible during DONE belong to the completing instruction and are ignored.
- Timing:
  - A request first seen in IDLE at cycle N holds stall_o=1 for cycles N..N+LATENCY.
  - ack_o=1 at cycle N+LATENCY+1.
  - The next request can begin at cycle N+LATENCY+2.
- Ordering:
  - A read after a write to the same word returns the written value.
  - Back-to-back accesses never overlap.
- Writes do not change data_o.
- Reset mid-operation (BUSY): returns to IDLE. A pending write is discarded and the array is unchanged. No ack_o is issued.
- LATENCY values outside 1..15 are illegal (elaboration-time check).

Test Plan:
1. Reset with rst_i=0 mid-cycle, then release -> data_o=0, stall_o=0, ack_o=0 immediately, with no clock edge required.
2. LATENCY=2:
   - Write addr=0x10, data=0xDEADBEEF at cycle 5 -> stall_o high for cycles 5-7, ack_o high at cycle 8, stall_o low at cycle 8.
   - Then read 0x10 -> data_o=0xDEADBEEF on its ack cycle.
3. Write 0x11223344 to addr 0x4, then read addr 0x404 with DEPTH=256 -> wrap-around returns 0x11223344. Read addr 0x7 -> also word 1, returns 0x11223344.
4. MemRead_i and MemWrite_i both high, addr 0x20, data 0xA5A5A5A5 -> treated as a write; a later read of 0x20 gives 0xA5A5A5A5, and data_o is unchanged on the dual-request ack.
5. Write 0x0BADF00D to 0x30, then drive rst_i=0 during BUSY -> no ack_o, state returns to IDLE, and a later read of 0x30 returns the prior value.
6. Request held high through DONE for back-to-back loads, LATENCY=1 -> exactly one ack_o per access, acks spaced 3 cycles apart, no access issued from the DONE cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: services EX/MEM loads/stores from a
// word array after a fixed number of wait states, stalling the pipeline meanwhile.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                req_c;
    logic                stall_c;
    logic                mem_we_c;
    logic                unused_addr_c;

    assign req_c         = MemRead_i | MemWrite_i;
    assign unused_addr_c = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // Next-state and access control; a dual request is treated as a write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        stall_c  = 1'b0;
        mem_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = req_c;
                if (req_c) begin
                    op_wr_d = MemWrite_i;
                    idx_d   = addr_i[IDX_W+1:2];
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (op_wr_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    // Array is deliberately not reset; a write cut short by reset never reaches here.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign data_o  = rdata_q;
    assign ack_o   = ack_q;
    assign stall_o = rst_i & stall_c;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) checked every cycle
// against a timeline model, plus hand-computed literal expectations.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd, wr, stall, ack;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] dout [2];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;

    // model state
    bit          pend [2];
    int          st [2];
    bit          pw [2];
    int          pidx [2];
    logic [31:0] pd [2];
    logic [31:0] exp_d [2];
    logic [31:0] mmem [2][256];
    logic        es [2];
    logic        ea [2];

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
        .addr_i(ad[0]), .data_i(wd[0]), .data_o(dout[0]), .stall_o(stall[0]), .ack_o(ack[0])
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
        .addr_i(ad[1]), .data_i(wd[1]), .data_o(dout[1]), .stall_o(stall[1]), .ack_o(ack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Timeline model: a request seen idle at cycle s stalls s..s+L and acks at s+L+1.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    pend[k]  = 1'b0;
                    exp_d[k] = 32'h0;
                    es[k]    = 1'b0;
                    ea[k]    = 1'b0;
                end else if (pend[k]) begin
                    es[k] = (cyc <= st[k] + lat_of(k));
                    ea[k] = (cyc == st[k] + lat_of(k) + 1);
                    if (ea[k]) begin
                        if (pw[k]) mmem[k][pidx[k]] = pd[k];
                        else       exp_d[k] = mmem[k][pidx[k]];
                        pend[k] = 1'b0;
                    end
                end else begin
                    es[k] = rd[k] | wr[k];
                    ea[k] = 1'b0;
                    if (es[k]) begin
                        pend[k] = 1'b1;
                        st[k]   = cyc;
                        pw[k]   = wr[k];
                        pidx[k] = int'(ad[k][9:2]);
                        pd[k]   = wd[k];
                    end
                end
                chk($sformatf("stall%0d", k), {31'h0, stall[k]}, {31'h0, es[k]});
                chk($sformatf("ack%0d", k),   {31'h0, ack[k]},   {31'h0, ea[k]});
                chk($sformatf("data%0d", k),  dout[k], exp_d[k]);
            end
        end
    end

    // Issue one access at posedge+1; report cycles to ack, stall cycles seen, data at ack.
    task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int lat_seen, output int stall_cnt,
                          output logic [31:0] dat);
        int  t0;
        bit  got;
        rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
        t0 = cyc;
        got = 1'b0;
        lat_seen = -1;
        stall_cnt = 0;
        dat = 32'h0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack[k]) begin
                got = 1'b1;
                lat_seen = cyc - t0;
                dat = dout[k];
                if (stall[k]) stall_cnt = 99;
            end else if (stall[k]) begin
                stall_cnt++;
            end
        end
        @(posedge clk);
        #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
        if (!got) begin
            nvec++;
            nerr++;
            $display("FAIL timeout on instance %0d: no ack within 40 cycles", k);
        end
    endtask

    int          lat, scnt, t0, nack;
    logic [31:0] dat;
    int          ackc [8];

    initial begin
        rst_n = 1'b1;
        rd = '0; wr = '0;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;

        // 1: reset asserted mid-cycle, checked before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_data0", dout[0], 32'h0);
        chk("rst_stall0", {31'h0, stall[0]}, 32'h0);
        chk("rst_ack0", {31'h0, ack[0]}, 32'h0);
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: write then read back, LATENCY=2
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, scnt, dat);
        chk("wr_ack_latency", lat, 3);
        chk("wr_stall_cycles", scnt, 3);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, scnt, dat);
        chk("rd_data_0x10", dat, 32'hDEADBEEF);
        chk("rd_ack_latency", lat, 3);

        // 3: address wrap and ignored byte offset
        access(0, 1'b0, 1'b1, 32'h4, 32'h11223344, lat, scnt, dat);
        access(0, 1'b1, 1'b0, 32'h404, 32'h0, lat, scnt, dat);
        chk("rd_wrap_0x404", dat, 32'h11223344);
        access(0, 1'b1, 1'b0, 32'h7, 32'h0, lat, scnt, dat);
        chk("rd_offset_0x7", dat, 32'h11223344);

        // 4: dual request is a write and leaves data_o alone
        access(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, lat, scnt, dat);
        chk("dual_data_held", dat, 32'h11223344);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, scnt, dat);
        chk("rd_dual_0x20", dat, 32'hA5A5A5A5);

        // 5: reset during BUSY discards the pending write
        access(0, 1'b0, 1'b1, 32'h30, 32'h13572468, lat, scnt, dat);
        wr[0] = 1'b1; ad[0] = 32'h30; wd[0] = 32'h0BADF00D;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_data", dout[0], 32'h0);
        chk("midrst_stall", {31'h0, stall[0]}, 32'h0);
        chk("midrst_ack", {31'h0, ack[0]}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, scnt, dat);
        chk("rd_after_rst_0x30", dat, 32'h13572468);

        // 6: held load request, LATENCY=1 -> one ack every 3 cycles
        access(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, lat, scnt, dat);
        chk("l1_wr_latency", lat, 2);
        rd[1] = 1'b1; ad[1] = 32'h8;
        t0 = cyc;
        nack = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack[1]) begin
                if (nack < 8) ackc[nack] = cyc - t0;
                nack++;
                chk("l1_rd_data", dout[1], 32'hCAFEF00D);
            end
        end
        @(posedge clk); #1;
        rd[1] = 1'b0;
        chk("l1_ack_count", nack, 4);
        if (nack >= 4) begin
            chk("l1_first_ack", ackc[0], 2);
            chk("l1_spacing_a", ackc[1] - ackc[0], 3);
            chk("l1_spacing_b", ackc[3] - ackc[2], 3);
        end
        repeat (4) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
